// File: rtl/alu_arbiter2_if.sv
// Shared-ALU bus between the arbiter and the ALU it drives.
//   master (arbiter): alu_start, alu_op, alu_a, alu_b out; alu_done, alu_result in
//   slave  (ALU)    : the reverse directions
interface alu_arbiter2_if #(
  parameter int unsigned WIDTH = 32
);
  logic             alu_start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_result
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_result
  );
endinterface

// File: rtl/alu_arbiter2.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// A granted request is latched, issued to the ALU with a one-cycle start
// pulse, and completed either by alu_done or by a WAIT-cycle timeout.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/req1           operation requests
//   op0/op1, a0/b0/a1/b1 opcode and operands per requester
//   gnt0/gnt1           grant held from START through DONE
//   alu (master)        shared ALU bus (start/op/a/b out, done/result in)
//   ack0/ack1           one-cycle completion pulse to the granted requester
//   result              registered result, valid in the ack cycle, held after
//   err                 timeout flag, pulses with ack
module alu_arbiter2 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       op0,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  alu_arbiter2_if.master   alu,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_last;   // 1 = requester 1 served last
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic [CW-1:0]    r_cnt;    // completed WAIT cycles without alu_done
  logic             w_pick0;
  logic             w_pick1;
  logic             w_timeout;

  always_comb begin
    w_next    = r_state;
    w_pick0   = 1'b0;
    w_pick1   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie, serve whoever was not served last.
        if (req0 && (!req1 || r_last)) w_pick0 = 1'b1;
        else if (req1)                 w_pick1 = 1'b1;
        if (w_pick0 || w_pick1) w_next = S_START;
      end
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        // alu_done takes priority over a timeout in the same cycle.
        if (alu.alu_done) begin
          w_next = S_DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_last   <= 1'b1;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_pick0) begin
            r_gnt0 <= 1'b1;
            r_op   <= op0;
            r_a    <= a0;
            r_b    <= b0;
          end else if (w_pick1) begin
            r_gnt1 <= 1'b1;
            r_op   <= op1;
            r_a    <= a1;
            r_b    <= b1;
          end
        end
        S_WAIT: begin
          if (alu.alu_done) begin
            r_result <= alu.alu_result;
            r_err    <= 1'b0;
            r_cnt    <= '0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_last <= r_gnt1;
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign gnt0          = r_gnt0;
  assign gnt1          = r_gnt1;
  assign alu.alu_start = (r_state == S_START);
  // Latched operands are visible only while an operation is in flight.
  assign alu.alu_op    = (r_state == S_IDLE) ? '0 : r_op;
  assign alu.alu_a     = (r_state == S_IDLE) ? '0 : r_a;
  assign alu.alu_b     = (r_state == S_IDLE) ? '0 : r_b;
  assign ack0          = (r_state == S_DONE) && r_gnt0;
  assign ack1          = (r_state == S_DONE) && r_gnt1;
  assign result        = r_result;
  assign err           = r_err;

endmodule

// File: tb/tb_alu_arbiter2.sv
module tb_alu_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, ack0, ack1, err;
  logic [31:0] result;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  alu_arbiter2_if #(.WIDTH(32)) alu_bus ();

  alu_arbiter2 #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .op0    (op0),
    .op1    (op1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .alu    (alu_bus.master),
    .ack0   (ack0),
    .ack1   (ack1),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    chk("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
    chk("ack_excl", 64'(ack0 & ack1), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    alu_bus.alu_done = 1'b0; alu_bus.alu_result = '0;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_gnt",   {62'd0, gnt0, gnt1}, 64'd0);
    chk("rst_start", 64'(alu_bus.alu_start), 64'd0);
    chk("rst_bus",   64'({alu_bus.alu_op, alu_bus.alu_a} | 64'(alu_bus.alu_b)), 64'd0);
    chk("rst_ack",   {62'd0, ack0, ack1}, 64'd0);
    chk("rst_res",   64'(result), 64'd0);
    chk("rst_err",   64'(err), 64'd0);

    // Single request, done three cycles after start
    req0 = 1; op0 = 4'h2; a0 = 5; b0 = 7;
    cyc();
    chk("r0_gnt0",  64'(gnt0), 64'd1);
    chk("r0_gnt1",  64'(gnt1), 64'd0);
    chk("r0_start", 64'(alu_bus.alu_start), 64'd1);
    chk("r0_op",    64'(alu_bus.alu_op), 64'h2);
    chk("r0_a",     64'(alu_bus.alu_a), 64'd5);
    chk("r0_b",     64'(alu_bus.alu_b), 64'd7);
    req0 = 0; a0 = 99; b0 = 98; op0 = 4'hF;
    cyc();
    chk("r0_start_1cyc", 64'(alu_bus.alu_start), 64'd0);
    chk("r0_a_held",     64'(alu_bus.alu_a), 64'd5);
    cyc(); cyc();
    alu_bus.alu_done = 1; alu_bus.alu_result = 12;
    cyc();
    alu_bus.alu_done = 0; alu_bus.alu_result = 0;
    chk("r0_ack0", 64'(ack0), 64'd1);
    chk("r0_ack1", 64'(ack1), 64'd0);
    chk("r0_res",  64'(result), 64'd12);
    chk("r0_err",  64'(err), 64'd0);
    chk("r0_op_done", 64'(alu_bus.alu_op), 64'h2);
    cyc();
    chk("r0_idle_ack",  64'(ack0), 64'd0);
    chk("r0_idle_gnt",  64'(gnt0), 64'd0);
    chk("r0_idle_res",  64'(result), 64'd12);
    chk("r0_idle_a",    64'(alu_bus.alu_a), 64'd0);

    // Round robin with both requests held, after a fresh reset
    rst = 1; cyc(); rst = 0;
    req0 = 1; req1 = 1; a0 = 1; a1 = 2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_gnt0", 64'(gnt0), 64'(i % 2 == 0));
      chk("rr_gnt1", 64'(gnt1), 64'(i % 2 == 1));
      chk("rr_a",    64'(alu_bus.alu_a), (i % 2 == 0) ? 64'd1 : 64'd2);
      cyc();
      alu_bus.alu_done = 1; alu_bus.alu_result = 32'(100 + i);
      cyc();
      alu_bus.alu_done = 0;
      chk("rr_ack0", 64'(ack0), 64'(i % 2 == 0));
      chk("rr_ack1", 64'(ack1), 64'(i % 2 == 1));
      chk("rr_res",  64'(result), 64'(100 + i));
      cyc();
    end
    req0 = 0; req1 = 0;

    // Timeout on requester 1, then requester 0 is still served
    req1 = 1; op1 = 4'h3;
    cyc();
    chk("to_gnt1", 64'(gnt1), 64'd1);
    req1 = 0;
    cyc();
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk("to_wait_ack", 64'(ack1), 64'd0);
    end
    cyc();
    chk("to_ack1", 64'(ack1), 64'd1);
    chk("to_err",  64'(err), 64'd1);
    chk("to_res",  64'(result), 64'd0);
    cyc();
    chk("to_err_clr", 64'(err), 64'd0);
    chk("to_gnt_clr", 64'(gnt1), 64'd0);
    req0 = 1; a0 = 11;
    cyc();
    req0 = 0;
    chk("to_next_gnt0", 64'(gnt0), 64'd1);
    cyc();
    alu_bus.alu_done = 1; alu_bus.alu_result = 55;
    cyc();
    alu_bus.alu_done = 0;
    chk("to_next_ack0", 64'(ack0), 64'd1);
    chk("to_next_res",  64'(result), 64'd55);
    cyc();

    // alu_done on the same cycle the timeout is reached
    req0 = 1;
    cyc();
    req0 = 0;
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    alu_bus.alu_done = 1; alu_bus.alu_result = 32'hDEADBEEF;
    cyc();
    alu_bus.alu_done = 0;
    chk("tie_ack0", 64'(ack0), 64'd1);
    chk("tie_res",  64'(result), 64'hDEADBEEF);
    chk("tie_err",  64'(err), 64'd0);
    cyc();

    // Reset during WAIT: no ack, pointer back to favour req0
    req1 = 1;
    cyc();
    req1 = 0;
    cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rw_gnt",  {62'd0, gnt0, gnt1}, 64'd0);
    chk("rw_ack",  {62'd0, ack0, ack1}, 64'd0);
    chk("rw_bus",  64'({alu_bus.alu_start, alu_bus.alu_op} | 64'(alu_bus.alu_a)), 64'd0);
    chk("rw_res",  64'(result), 64'd0);
    chk("rw_err",  64'(err), 64'd0);
    alu_bus.alu_done = 1; alu_bus.alu_result = 7;
    cyc();
    alu_bus.alu_done = 0;
    chk("rw_no_ack", {62'd0, ack0, ack1}, 64'd0);
    chk("rw_res2",   64'(result), 64'd0);
    req0 = 1; req1 = 1;
    cyc();
    req0 = 0; req1 = 0;
    chk("rw_tie_gnt0", 64'(gnt0), 64'd1);
    chk("rw_tie_gnt1", 64'(gnt1), 64'd0);
    cyc();
    alu_bus.alu_done = 1; alu_bus.alu_result = 1;
    cyc();
    alu_bus.alu_done = 0;
    chk("rw_tie_ack0", 64'(ack0), 64'd1);
    cyc();

    // alu_done outside WAIT is ignored; requests in WAIT are ignored
    alu_bus.alu_done = 1; alu_bus.alu_result = 66;
    cyc();
    chk("ig_idle_start", 64'(alu_bus.alu_start), 64'd0);
    chk("ig_idle_ack",   {62'd0, ack0, ack1}, 64'd0);
    req1 = 1; op1 = 4'h5; a1 = 3; b1 = 4;
    cyc();
    chk("ig_gnt1", 64'(gnt1), 64'd1);
    cyc();
    alu_bus.alu_done = 0;
    chk("ig_start_ack",  {62'd0, ack0, ack1}, 64'd0);
    chk("ig_start_over", 64'(alu_bus.alu_start), 64'd0);
    req1 = 0; a1 = 77; op1 = 4'h9;
    cyc();
    req1 = 1; req0 = 1;
    cyc();
    chk("ig_wait_ack", {62'd0, ack0, ack1}, 64'd0);
    chk("ig_wait_gnt", {62'd0, gnt0, gnt1}, 64'd1);
    chk("ig_wait_a",   64'(alu_bus.alu_a), 64'd3);
    chk("ig_wait_op",  64'(alu_bus.alu_op), 64'h5);
    req0 = 0; req1 = 0;
    alu_bus.alu_done = 1; alu_bus.alu_result = 9;
    cyc();
    alu_bus.alu_done = 0;
    chk("ig_ack1", 64'(ack1), 64'd1);
    chk("ig_res",  64'(result), 64'd9);
    cyc();
    chk("ig_idle_a", 64'(alu_bus.alu_a), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
